// File: rtl/coeff_bank_dbuf.sv
// Double-buffered FIR coefficient store: 1-cycle reads, commits swap at a sample strobe; writes rejected while busy.
// Optional build macro COEFF_SUM_EN adds a per-commit tap checksum (oSumDt) computed before the swap.
module coeff_bank_dbuf #(
  parameter int NUM_TAPS = 10,
  parameter int COEF_W   = 16,
  parameter int ADDR_W   = 4
`ifdef COEFF_SUM_EN
  , parameter int SUM_W  = COEF_W + $clog2(NUM_TAPS)
`endif
) (
  input  logic                       iClk,
  input  logic                       iRst,
  input  logic                       iCsn,
  input  logic                       iWrn,
  input  logic [ADDR_W-1:0]          iAddr,
  input  logic [COEF_W-1:0]          iWrDt,
  input  logic                       iBankSel,
  output logic [COEF_W-1:0]          oRdDt,
  input  logic                       iCommit,
  input  logic                       iSampleStb,
  output logic                       oBusy,
  output logic                       oCommitDone,
  output logic                       oWrRej,
  output logic [7:0]                 oCommitCnt,
  output logic [NUM_TAPS*COEF_W-1:0] oCoeff
`ifdef COEFF_SUM_EN
  , output logic [SUM_W-1:0]         oSumDt
`endif
);

  typedef enum logic [1:0] {IDLE, SUM, WAIT} state_t;

  localparam logic [ADDR_W:0]   TAPS = (ADDR_W+1)'(NUM_TAPS);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_TAPS - 1);

  state_t                   state;
  logic signed [COEF_W-1:0] shadow [NUM_TAPS];
  logic signed [COEF_W-1:0] active [NUM_TAPS];
  logic                     inRange;
  logic                     wrReq;
  logic                     rdReq;

`ifdef COEFF_SUM_EN
  logic signed [SUM_W-1:0]  acc;
  logic [ADDR_W-1:0]        idx;
`endif

  assign inRange = ({1'b0, iAddr} < TAPS);
  assign wrReq   = !iCsn && !iWrn;
  assign rdReq   = !iCsn && iWrn;

  // The active bank is the MAC-facing tap vector; it only moves on the swap edge.
  for (genvar k = 0; k < NUM_TAPS; k++) begin : gCoeff
    assign oCoeff[k*COEF_W +: COEF_W] = active[k];
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow[k] <= '0;
        active[k] <= '0;
      end
      state       <= IDLE;
      oRdDt       <= '0;
      oBusy       <= 1'b0;
      oCommitDone <= 1'b0;
      oWrRej      <= 1'b0;
      oCommitCnt  <= '0;
`ifdef COEFF_SUM_EN
      acc         <= '0;
      idx         <= '0;
      oSumDt      <= '0;
`endif
    end else begin
      oCommitDone <= 1'b0;
      oWrRej      <= 1'b0;

      // Out-of-range writes vanish silently, even while busy.
      if (wrReq && inRange) begin
        if (oBusy) oWrRej <= 1'b1;
        else       shadow[iAddr] <= iWrDt;
      end

      if (rdReq) begin
        if (!inRange)      oRdDt <= '0;
        else if (iBankSel) oRdDt <= shadow[iAddr];
        else               oRdDt <= active[iAddr];
      end

      case (state)
        IDLE: begin
          if (iCommit) begin
            oBusy <= 1'b1;
`ifdef COEFF_SUM_EN
            state <= SUM;
            idx   <= '0;
            acc   <= '0;
`else
            state <= WAIT;
`endif
          end
        end
`ifdef COEFF_SUM_EN
        SUM: begin
          acc <= acc + SUM_W'(shadow[idx]);
          if (idx == LAST) state <= WAIT;
          else             idx   <= idx + ADDR_W'(1);
        end
`endif
        WAIT: begin
          if (iSampleStb) begin
            for (int k = 0; k < NUM_TAPS; k++) active[k] <= shadow[k];
            oCommitDone <= 1'b1;
            oCommitCnt  <= oCommitCnt + 8'd1;
`ifdef COEFF_SUM_EN
            oSumDt      <= acc;
`endif
            state       <= IDLE;
            oBusy       <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule
